lc_mem_burst_seq: RTL and testbench
===================================

// Module: lc_mem_burst_seq
// PURPOSE
//  Burst sequencer upstream of the layer-controller memory controller. Accepts one burst command
//  (start addr, length, direction) and issues one four-phase MEM_REQ/MEM_ACK handshake per word.
//  Streams write data in and read data out through valid/ready ports. Sits between the MBus
//  command decoder and the memory controller.
// PARAMETERS
//  LEN_WIDTH       8    width of CMD_LEN; burst = CMD_LEN+1 words (1..2^LEN_WIDTH)
//  TIMEOUT_CYCLES  255  max cycles waiting on MEM_ACK_OUT edge (only with LC_MEM_BURST_TIMEOUT_EN)
// PORTS
//  CLK          in   1                    clock
//  RESETn       in   1                    reset, asynchronous, active-low
//  CMD_VALID    in   1                    burst command valid
//  CMD_READY    out  1                    sequencer idle, command accepted when VALID&READY
//  CMD_WRITE    in   1                    1=write burst, 0=read burst
//  CMD_ADDR     in   `LC_MEM_ADDR_WIDTH   start word address
//  CMD_LEN      in   LEN_WIDTH            words-1
//  WDATA_VALID  in   1                    write word valid
//  WDATA        in   `LC_MEM_DATA_WIDTH   write word
//  WDATA_READY  out  1                    write word consumed
//  RDATA_VALID  out  1                    read word valid
//  RDATA        out  `LC_MEM_DATA_WIDTH   read word
//  RDATA_READY  in   1                    consumer accepts read word
//  MEM_REQ      out  1                    request to memory controller
//  MEM_WRITE    out  1                    request direction
//  ADDR         out  `LC_MEM_ADDR_WIDTH   request address
//  DATA_IN      out  `LC_MEM_DATA_WIDTH   write data to memory
//  DATA_OUT     in   `LC_MEM_DATA_WIDTH   read data from memory
//  MEM_ACK_OUT  in   1                    memory acknowledge
//  BUSY         out  1                    burst in progress
//  DONE         out  1                    one-cycle pulse, burst complete
//  ERR          out  1                    sticky timeout flag, cleared on next command accept
// BEHAVIOUR
//  Reset: all outputs 0 except CMD_READY=1; FSM=IDLE; counters 0.
//  FSM: IDLE -> (CMD_VALID) latch addr/len/dir, BUSY=1 -> WR ? WFETCH : REQ.
//   WFETCH: WDATA_READY=1; on WDATA_VALID latch into DATA_IN -> REQ (1-cycle accept).
//   REQ: MEM_REQ=1, ADDR/MEM_WRITE/DATA_IN stable; on MEM_ACK_OUT=1 -> RELEASE; reads capture
//        DATA_OUT into RDATA on that same edge.
//   RELEASE: MEM_REQ=0; wait MEM_ACK_OUT=0 (four-phase). Then read -> RDOUT; write -> NEXT.
//   RDOUT: RDATA_VALID=1 held, RDATA stable until RDATA_READY -> NEXT.
//   NEXT: remaining==0 -> IDLE with DONE pulse, BUSY=0; else ADDR+1, remaining-1 -> WFETCH/REQ.
//  MEM_REQ never reasserted while MEM_ACK_OUT high. ADDR increments modulo 2^ADDR_WIDTH (wraps).
//  CMD_READY=1 only in IDLE; commands while busy are held off, not dropped.
//  Min per-word latency: write 4 cycles, read 4 cycles + consumer stall, given 1-cycle ACK rise/fall.
//  ACK already high in IDLE/REQ entry: REQ waits; handshake only counts a 0->1 seen in REQ.
//  Reset mid-burst: abort immediately, MEM_REQ drops asynchronously, no DONE.
// CONFIGURATION
//  LC_MEM_BURST_TIMEOUT_EN defined: cycle counter in REQ and RELEASE; reaching TIMEOUT_CYCLES
//   sets ERR, drops MEM_REQ, returns to IDLE with DONE pulse, remaining words abandoned.
//  Undefined: no counter, ERR tied 0, waits on ACK indefinitely.
// STRUCTURE
//  Shared package/include: FSM state encodings (3-bit), LC_MEM_ADDR_WIDTH/DATA_WIDTH from mbus_def.
//  One sub-module natural: lc_mem_burst_timer (load/count/expire) instantiated only under the macro.
// TESTING
//  Write burst ADDR=0x10 LEN=3, data 0xA0..0xA3 -> 4 REQs at 0x10..0x13, DONE once, mem matches.
//  Read burst ADDR=0x10 LEN=3, RDATA_READY held low 5 cycles/word -> RDATA 0xA0..0xA3, no REQ overlap.
//  ADDR=all-ones LEN=1 write -> second REQ at ADDR=0, then DONE.
//  WDATA_VALID stalled 10 cycles -> MEM_REQ stays 0, no spurious write.
//  Reset asserted in RELEASE -> MEM_REQ=0, CMD_READY=1, no DONE; new burst runs clean.
//  Timeout EN: ACK never rises -> ERR=1 after 255 cycles in REQ, DONE pulse, IDLE; next CMD clears ERR.

Source files
------------

// File: rtl/lc_mem_burst_seq_pkg.sv
// rtl/lc_mem_burst_seq_pkg.sv - shared memory widths and FSM state encodings for the burst sequencer
`ifndef LC_MEM_ADDR_WIDTH
`define LC_MEM_ADDR_WIDTH 30
`endif
`ifndef LC_MEM_DATA_WIDTH
`define LC_MEM_DATA_WIDTH 32
`endif

package lc_mem_burst_seq_pkg;

  localparam int ADDR_WIDTH = `LC_MEM_ADDR_WIDTH;
  localparam int DATA_WIDTH = `LC_MEM_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WFETCH  = 3'd1,
    ST_REQ     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RDOUT   = 3'd4,
    ST_NEXT    = 3'd5
  } state_e;

endpackage

// File: rtl/lc_mem_burst_seq_if.sv
// rtl/lc_mem_burst_seq_if.sv - command, data stream and memory handshake bundle of the burst sequencer
interface lc_mem_burst_seq_if #(
  parameter int LEN_WIDTH = 8
);
  import lc_mem_burst_seq_pkg::*;

  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [LEN_WIDTH-1:0]  CMD_LEN;
  logic                  WDATA_VALID;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WDATA_READY;
  logic                  RDATA_VALID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RDATA_READY;
  logic                  MEM_REQ;
  logic                  MEM_WRITE;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  MEM_ACK_OUT;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;

  // sequencer side
  modport slave (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, WDATA_VALID, WDATA, RDATA_READY,
           DATA_OUT, MEM_ACK_OUT,
    output CMD_READY, WDATA_READY, RDATA_VALID, RDATA, MEM_REQ, MEM_WRITE, ADDR, DATA_IN,
           BUSY, DONE, ERR
  );

  // command source, stream endpoints and memory controller side
  modport master (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, WDATA_VALID, WDATA, RDATA_READY,
           DATA_OUT, MEM_ACK_OUT,
    input  CMD_READY, WDATA_READY, RDATA_VALID, RDATA, MEM_REQ, MEM_WRITE, ADDR, DATA_IN,
           BUSY, DONE, ERR
  );

endinterface

// File: rtl/lc_mem_burst_seq_timer.sv
// rtl/lc_mem_burst_seq_timer.sv - wait-cycle counter for the handshake timeout, present only with LC_MEM_BURST_TIMEOUT_EN
`ifdef LC_MEM_BURST_TIMEOUT_EN
module lc_mem_burst_seq_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // expire fires on the TIMEOUT_CYCLES-th consecutive enabled cycle
  assign expire = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // restart on every state change, otherwise count enabled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/lc_mem_burst_seq.sv
// rtl/lc_mem_burst_seq.sv - burst sequencer, one four-phase MEM_REQ/MEM_ACK per word; LC_MEM_BURST_TIMEOUT_EN adds an ACK timeout
module lc_mem_burst_seq
  import lc_mem_burst_seq_pkg::*;
#(
  parameter int LEN_WIDTH = 8
`ifdef LC_MEM_BURST_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic               CLK,
  input logic               RESETn,
  lc_mem_burst_seq_if.slave bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  armed_q, armed_d;
  logic                  done_q, done_d;
  logic                  timeout;

`ifdef LC_MEM_BURST_TIMEOUT_EN
  logic err_q, err_d;

  lc_mem_burst_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .RESETn (RESETn),
    .clear  (state_d != state_q),
    .en     ((state_q == ST_REQ) || (state_q == ST_RELEASE)),
    .expire (timeout)
  );

  // sticky error: set by a timeout, cleared when the next command is taken
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && bus.CMD_VALID) begin
      err_d = 1'b0;
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  // error flag register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.ERR = err_q;
`else
  assign timeout = 1'b0;
  assign bus.ERR = 1'b0;
`endif

  // next-state and datapath for the per-word handshake sequence
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    write_d   = write_q;
    data_in_d = data_in_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    armed_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.CMD_VALID) begin
          addr_d  = bus.CMD_ADDR;
          rem_d   = bus.CMD_LEN;
          write_d = bus.CMD_WRITE;
          state_d = bus.CMD_WRITE ? ST_WFETCH : ST_REQ;
        end
      end
      ST_WFETCH: begin
        if (bus.WDATA_VALID) begin
          data_in_d = bus.WDATA;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // only a rising ACK observed after the request was armed completes the word
        if (armed_q && bus.MEM_ACK_OUT) begin
          if (!write_q) begin
            rdata_d = bus.DATA_OUT;
          end
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.MEM_ACK_OUT) begin
          state_d = write_q ? ST_NEXT : ST_RDOUT;
        end
      end
      ST_RDOUT: begin
        if (bus.RDATA_READY) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (rem_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = write_q ? ST_WFETCH : ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // abandoning the burst on a stuck handshake still reports completion
    if (timeout) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end

    // arm the request only once ACK has been seen low, so MEM_REQ never rises into a high ACK
    if (state_d == ST_REQ) begin
      armed_d = (state_q == ST_REQ) ? (armed_q | ~bus.MEM_ACK_OUT) : ~bus.MEM_ACK_OUT;
    end
  end

  // state and datapath registers, cleared asynchronously so MEM_REQ drops at once on reset
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      write_q   <= 1'b0;
      data_in_q <= '0;
      rdata_q   <= '0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      write_q   <= write_d;
      data_in_q <= data_in_d;
      rdata_q   <= rdata_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
    end
  end

  assign bus.CMD_READY   = (state_q == ST_IDLE);
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.WDATA_READY = (state_q == ST_WFETCH);
  assign bus.RDATA_VALID = (state_q == ST_RDOUT);
  assign bus.RDATA       = rdata_q;
  assign bus.MEM_REQ     = (state_q == ST_REQ) && armed_q;
  assign bus.MEM_WRITE   = write_q;
  assign bus.ADDR        = addr_q;
  assign bus.DATA_IN     = data_in_q;
  assign bus.DONE        = done_q;

endmodule

// File: tb/tb_lc_mem_burst_seq.sv
// tb/tb_lc_mem_burst_seq.sv - self-checking bench for lc_mem_burst_seq with a behavioural memory model
module tb_lc_mem_burst_seq;
  import lc_mem_burst_seq_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int LW = 8;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  lc_mem_burst_seq_if #(.LEN_WIDTH(LW)) bus ();

  lc_mem_burst_seq #(.LEN_WIDTH(LW)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    bit            w;
    logic [DW-1:0] d;
  } req_t;

  req_t          log_q[$];
  logic [DW-1:0] phys [logic [AW-1:0]];
  logic [DW-1:0] model [logic [AW-1:0]];

  bit mute = 0, hold = 0, force_ack = 0;
  int overlap = 0, spurious = 0, forced_req = 0, done_pulses = 0, dly = 0;
  bit prev_req = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model.exists(a) ? model[a] : {DW{1'b1}};
  endfunction

  // memory controller model: four-phase ACK with random rise delay, plus protocol monitors
  initial begin
    bus.MEM_ACK_OUT = 1'b0;
    bus.DATA_OUT    = '0;
    forever begin
      @(negedge CLK);
      if (bus.MEM_REQ && !prev_req && bus.MEM_ACK_OUT) overlap++;
      if (bus.MEM_REQ && bus.WDATA_READY) spurious++;
      if (bus.MEM_REQ && force_ack) forced_req++;
      if (bus.DONE) done_pulses++;
      prev_req = bus.MEM_REQ;
      if (force_ack) begin
        bus.MEM_ACK_OUT = 1'b1;
      end else if (bus.MEM_REQ && !bus.MEM_ACK_OUT && !mute) begin
        if (dly > 0) begin
          dly--;
        end else begin
          log_q.push_back('{bus.ADDR, bus.MEM_WRITE, bus.DATA_IN});
          if (bus.MEM_WRITE) phys[bus.ADDR] = bus.DATA_IN;
          bus.DATA_OUT    = phys.exists(bus.ADDR) ? phys[bus.ADDR] : {DW{1'b1}};
          bus.MEM_ACK_OUT = 1'b1;
          dly = $urandom_range(0, 2);
        end
      end else if (!bus.MEM_REQ && bus.MEM_ACK_OUT && !hold) begin
        bus.MEM_ACK_OUT = 1'b0;
      end
    end
  end

  // one whole burst: command, streamed data with stalls, completion, then request log and memory check
  task automatic run_burst(input bit wr, input logic [AW-1:0] a, input int len, input int base,
                           input int stall_max, input bit fixed);
    logic [DW-1:0] wd[$];
    logic [AW-1:0] ea;
    int widx = 0, ridx = 0, stall, cyc = 0, d0, l0, n;
    bit got_done = 0;
    for (int i = 0; i <= len; i++) wd.push_back(base >= 0 ? DW'(base + i) : DW'($urandom));
    d0 = done_pulses;
    l0 = log_q.size();
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = a;
    bus.CMD_LEN   = LW'(len);
    bus.CMD_VALID = 1'b1;
    while (!bus.CMD_READY && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    stall = fixed ? stall_max : $urandom_range(0, stall_max);
    cyc = 0;
    while (!got_done && cyc < 4000) begin
      if (wr) begin
        if (widx <= len && bus.WDATA_READY) begin
          if (stall > 0) begin
            bus.WDATA_VALID = 1'b0;
            stall--;
          end else begin
            bus.WDATA_VALID = 1'b1;
            bus.WDATA = wd[widx];
            widx++;
            stall = fixed ? stall_max : $urandom_range(0, stall_max);
          end
        end else begin
          bus.WDATA_VALID = 1'b0;
        end
      end else begin
        if (bus.RDATA_VALID) begin
          if (stall > 0) begin
            bus.RDATA_READY = 1'b0;
            stall--;
          end else begin
            ea = a + AW'(ridx);
            bus.RDATA_READY = 1'b1;
            chk("rdata", bus.RDATA, model_rd(ea));
            ridx++;
            stall = fixed ? stall_max : $urandom_range(0, stall_max);
          end
        end else begin
          bus.RDATA_READY = 1'b0;
        end
      end
      if (bus.DONE) got_done = 1;
      @(negedge CLK);
      cyc++;
    end
    bus.WDATA_VALID = 1'b0;
    bus.RDATA_READY = 1'b0;
    chk("done_seen", got_done, 1);
    chk("words_moved", wr ? widx : ridx, len + 1);
    @(negedge CLK);
    @(negedge CLK);
    chk("done_once", done_pulses - d0, 1);
    chk("idle_ready", bus.CMD_READY, 1);
    chk("idle_busy", bus.BUSY, 0);
    n = log_q.size() - l0;
    chk("req_count", n, len + 1);
    for (int i = 0; i <= len && i < n; i++) begin
      ea = a + AW'(i);
      chk("req_addr", log_q[l0 + i].a, ea);
      chk("req_dir", log_q[l0 + i].w, wr);
      if (wr) begin
        chk("req_wdata", log_q[l0 + i].d, wd[i]);
        model[ea] = wd[i];
        chk("mem_word", phys.exists(ea) ? phys[ea] : 'x, wd[i]);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, cyc, hi, d0;
    bus.CMD_VALID   = 1'b0;
    bus.CMD_WRITE   = 1'b0;
    bus.CMD_ADDR    = '0;
    bus.CMD_LEN     = '0;
    bus.WDATA_VALID = 1'b0;
    bus.WDATA       = '0;
    bus.RDATA_READY = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_cmd_ready", bus.CMD_READY, 1);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_mem_req", bus.MEM_REQ, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_err", bus.ERR, 0);
    chk("rst_rvalid", bus.RDATA_VALID, 0);
    chk("rst_wready", bus.WDATA_READY, 0);
    chk("rst_addr", bus.ADDR, 0);
    RESETn = 1'b1;
    @(negedge CLK);

    run_burst(1'b1, AW'(32'h10), 3, 32'hA0, 2, 1'b0);
    run_burst(1'b0, AW'(32'h10), 3, -1, 5, 1'b1);
    run_burst(1'b1, {AW{1'b1}}, 1, -1, 1, 1'b0);
    run_burst(1'b0, {AW{1'b1}}, 1, -1, 2, 1'b0);
    run_burst(1'b1, AW'(32'h40), 2, -1, 10, 1'b1);

    // ACK already high when the command arrives: no request until it has fallen
    force_ack = 1;
    @(negedge CLK);
    fork
      begin
        repeat (8) @(negedge CLK);
        force_ack = 0;
      end
    join_none
    run_burst(1'b0, AW'(32'h41), 0, -1, 0, 1'b0);
    chk("no_req_into_high_ack", forced_req, 0);

    for (int k = 0; k < 6; k++) begin
      run_burst(1'($urandom_range(0, 1)), AW'(32'h100 + $urandom_range(0, 15)),
                $urandom_range(0, 7), -1, 3, 1'b0);
    end

    // reset while the sequencer waits for ACK to fall
    hold = 1;
    d0 = done_pulses;
    l0 = log_q.size();
    bus.CMD_WRITE = 1'b1;
    bus.CMD_ADDR  = AW'(32'h80);
    bus.CMD_LEN   = LW'(3);
    bus.CMD_VALID = 1'b1;
    bus.WDATA     = DW'(32'h55);
    @(negedge CLK);
    bus.CMD_VALID   = 1'b0;
    bus.WDATA_VALID = 1'b1;
    cyc = 0;
    while (log_q.size() == l0 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
    chk("rel_reached", log_q.size() - l0, 1);
    bus.WDATA_VALID = 1'b0;
    @(negedge CLK);
    chk("rel_req_low", bus.MEM_REQ, 0);
    chk("rel_busy", bus.BUSY, 1);
    #2 RESETn = 1'b0;
    #1;
    chk("arst_mem_req", bus.MEM_REQ, 0);
    chk("arst_cmd_ready", bus.CMD_READY, 1);
    chk("arst_busy", bus.BUSY, 0);
    hold = 0;
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    chk("arst_no_done", done_pulses - d0, 0);
    run_burst(1'b1, AW'(32'h80), 1, -1, 2, 1'b0);
    run_burst(1'b0, AW'(32'h80), 1, -1, 2, 1'b0);

`ifdef LC_MEM_BURST_TIMEOUT_EN
    // ACK never rises: burst abandoned after the timeout with ERR and a DONE pulse
    mute = 1;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = AW'(32'h10);
    bus.CMD_LEN   = LW'(3);
    bus.CMD_VALID = 1'b1;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    hi = 0;
    cyc = 0;
    while (!bus.DONE && cyc < 600) begin
      if (bus.MEM_REQ) hi++;
      @(negedge CLK);
      cyc++;
    end
    chk("to_done", bus.DONE, 1);
    chk("to_req_cycles", hi, 255);
    chk("to_err", bus.ERR, 1);
    chk("to_idle", bus.CMD_READY, 1);
    mute = 0;
    run_burst(1'b0, AW'(32'h10), 0, -1, 1, 1'b0);
`endif

    chk("final_err", bus.ERR, 0);
    chk("req_overlap", overlap, 0);
    chk("req_during_wfetch", spurious, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
